// File: rtl/answer_reporter.sv
// Reports a solver result over UART 8N1: "ANS <decimal>\r\n" on Done or "ERR\r\n" on Error.
// One message per reset; the binary answer is converted to BCD by a bit-serial double-dabble.
module answer_reporter #(
  parameter int AnswerWidth = 64,
  parameter int ClksPerBit  = 1085
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Done,
  input  logic                   Error,
  input  logic [AnswerWidth-1:0] Answer,
  output logic                   Tx,
  output logic                   Busy,
  output logic                   Sent
);

  // ceil(AnswerWidth*log10(2)) using a fixed-point approximation of log10(2)
  localparam int NumDigits = (AnswerWidth * 30103 + 99999) / 100000;
  localparam int BcdW      = 4 * NumDigits;
  localparam int BaudW     = $clog2(ClksPerBit);
  localparam int CntW      = $clog2(AnswerWidth + 1);
  localparam int IdxW      = 8;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(AnswerWidth - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, SEND, FINISHED} state_t;

  state_t                 r_state;
  logic                   r_err;
  logic                   r_active;
  logic [CntW-1:0]        r_cnt;
  logic [BaudW-1:0]       r_baud;
  logic [3:0]             r_bit;
  logic [IdxW-1:0]        r_byte_idx;
  logic [AnswerWidth-1:0] r_shift;
  logic [BcdW-1:0]        r_bcd;

  logic [BcdW-1:0]        w_adj;
  logic [IdxW-1:0]        w_top;
  logic [IdxW-1:0]        w_pos;
  logic [IdxW-1:0]        w_last;
  logic [3:0]             w_nib;
  logic [7:0]             w_byte;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NumDigits; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Highest nonzero nibble; stays 0 for an all-zero result so a single '0' is sent
  always_comb begin
    w_top = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_top = IdxW'(i);
    end
  end

  always_comb begin
    w_pos = w_top - (r_byte_idx - 8'd4);
    w_nib = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (IdxW'(i) == w_pos) w_nib = r_bcd[4*i +: 4];
    end
    w_last = r_err ? 8'd4 : (w_top + 8'd6);
    w_byte = 8'h0A;
    if (r_err) begin
      case (r_byte_idx)
        8'd0:    w_byte = 8'h45;
        8'd1:    w_byte = 8'h52;
        8'd2:    w_byte = 8'h52;
        8'd3:    w_byte = 8'h0D;
        default: w_byte = 8'h0A;
      endcase
    end else begin
      case (r_byte_idx)
        8'd0:    w_byte = 8'h41;
        8'd1:    w_byte = 8'h4E;
        8'd2:    w_byte = 8'h53;
        8'd3:    w_byte = 8'h20;
        default: begin
          if (r_byte_idx <= w_top + 8'd4)      w_byte = 8'h30 + {4'h0, w_nib};
          else if (r_byte_idx == w_top + 8'd5) w_byte = 8'h0D;
          else                                 w_byte = 8'h0A;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_err      <= 1'b0;
      r_active   <= 1'b0;
      r_cnt      <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte_idx <= '0;
      Tx         <= 1'b1;
      Busy       <= 1'b0;
      Sent       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Error || Done) begin
            r_err      <= Error;
            r_active   <= 1'b0;
            r_byte_idx <= '0;
            r_cnt      <= '0;
            Busy       <= 1'b1;
            r_state    <= Error ? SEND : CONVERT;
          end
        end
        CONVERT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntLast) r_state <= SEND;
        end
        SEND: begin
          if (!r_active) begin
            r_active <= 1'b1;
            Tx       <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
          end else if (r_baud != BaudLast) begin
            r_baud <= r_baud + 1'b1;
          end else begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
              if (r_byte_idx == w_last) begin
                r_state  <= FINISHED;
                r_active <= 1'b0;
                Busy     <= 1'b0;
                Sent     <= 1'b1;
              end else begin
                // next start bit follows the stop bit with no idle gap
                r_byte_idx <= r_byte_idx + 1'b1;
                r_bit      <= '0;
                Tx         <= 1'b0;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
              Tx    <= (r_bit == 4'd8) ? 1'b1 : w_byte[r_bit[2:0]];
            end
          end
        end
        FINISHED: Tx <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (r_state == IDLE && Done && !Error) begin
      r_shift <= Answer;
      r_bcd   <= '0;
    end else if (r_state == CONVERT) begin
      r_bcd   <= {w_adj[BcdW-2:0], r_shift[AnswerWidth-1]};
      r_shift <= {r_shift[AnswerWidth-2:0], 1'b0};
    end
  end

endmodule
